// File: rtl/demux2_stream_if.sv
// demux2_stream_if
//   Stream bundle for the 1-to-2 demultiplexer: one producer-side input
//   stream with a destination select bit, and two consumer-side channels.
//   Parameter:
//     N          data width in bits
//   Signals:
//     in_data    input word           in_sel    destination (0 = A, 1 = B)
//     in_valid   input word present   in_ready  demux can accept this cycle
//     a_data     channel A word       a_valid   channel A holds a word
//     a_ready    channel A consumer accepts
//     b_data     channel B word       b_valid   channel B holds a word
//     b_ready    channel B consumer accepts
//   Modports:
//     slave      the demultiplexer side
//     master     the surrounding producer/consumer side
interface demux2_stream_if #(
  parameter int N = 16
) ();
  logic [N-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] b_data;
  logic         b_valid;
  logic         b_ready;

  modport slave (
    input  in_data, in_sel, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid
  );

  modport master (
    output in_data, in_sel, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid
  );
endinterface

// File: rtl/demux2_stream.sv
// demux2_stream
//   Registered 1-to-2 stream demultiplexer. Each input word is steered by
//   its select bit into a one-entry holding slot for channel A or B. The
//   slots are independent, so a stalled consumer only blocks words aimed at
//   its own channel. Per-channel 8-bit counters record accepted words.
//   Ports:
//     clk       rising-edge clock
//     rst       asynchronous, active-high reset
//     enable    1 = accept new words; 0 = input blocked, slots still drain
//     bus       stream bundle (slave side), see demux2_stream_if
//     a_count   words accepted into channel A since reset, modulo 256
//     b_count   words accepted into channel B since reset, modulo 256
module demux2_stream #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  demux2_stream_if.slave   bus,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
);

  logic [N-1:0] a_data_r;
  logic         a_valid_r;
  logic [7:0]   a_count_r;
  logic [N-1:0] b_data_r;
  logic         b_valid_r;
  logic [7:0]   b_count_r;

  logic         free_a_s;
  logic         free_b_s;
  logic         in_ready_s;
  logic         load_a_s;
  logic         load_b_s;
  logic         drain_a_s;
  logic         drain_b_s;

  // Slot availability, input handshake and per-slot load/drain strobes.
  // A slot is free when empty or when its current word leaves this edge,
  // which lets a full slot be refilled with no bubble.
  always_comb begin
    free_a_s   = 1'b0;
    free_b_s   = 1'b0;
    in_ready_s = 1'b0;
    load_a_s   = 1'b0;
    load_b_s   = 1'b0;
    drain_a_s  = 1'b0;
    drain_b_s  = 1'b0;

    free_a_s  = (!a_valid_r) || bus.a_ready;
    free_b_s  = (!b_valid_r) || bus.b_ready;
    drain_a_s = a_valid_r && bus.a_ready;
    drain_b_s = b_valid_r && bus.b_ready;

    if (enable) begin
      in_ready_s = bus.in_sel ? free_b_s : free_a_s;
    end else begin
      in_ready_s = 1'b0;
    end

    if (bus.in_valid && in_ready_s) begin
      load_a_s = !bus.in_sel;
      load_b_s = bus.in_sel;
    end else begin
      load_a_s = 1'b0;
      load_b_s = 1'b0;
    end
  end

  // Channel A slot and transfer counter; a load wins over a drain so a
  // same-edge drain+load keeps the slot valid with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_data_r  <= {N{1'b0}};
      a_valid_r <= 1'b0;
      a_count_r <= 8'd0;
    end else if (load_a_s) begin
      a_data_r  <= bus.in_data;
      a_valid_r <= 1'b1;
      a_count_r <= a_count_r + 8'd1;
    end else if (drain_a_s) begin
      a_valid_r <= 1'b0;
    end else begin
      a_valid_r <= a_valid_r;
    end
  end

  // Channel B slot and transfer counter, mirror of channel A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_data_r  <= {N{1'b0}};
      b_valid_r <= 1'b0;
      b_count_r <= 8'd0;
    end else if (load_b_s) begin
      b_data_r  <= bus.in_data;
      b_valid_r <= 1'b1;
      b_count_r <= b_count_r + 8'd1;
    end else if (drain_b_s) begin
      b_valid_r <= 1'b0;
    end else begin
      b_valid_r <= b_valid_r;
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.a_data   = a_data_r;
  assign bus.a_valid  = a_valid_r;
  assign bus.b_data   = b_data_r;
  assign bus.b_valid  = b_valid_r;
  assign a_count      = a_count_r;
  assign b_count      = b_count_r;

endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream
//   Scoreboard bench for demux2_stream: accepted input words are pushed to a
//   per-channel expected queue and popped/compared when the channel drains.
module tb_demux2_stream;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] a_count;
  logic [7:0] b_count;

  demux2_stream_if #(.N(16)) bus ();

  demux2_stream #(.N(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .bus     (bus),
    .a_count (a_count),
    .b_count (b_count)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit rnd          = 1'b0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [7:0]  m_a_cnt = 8'd0;
  logic [7:0]  m_b_cnt = 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: inputs are stable at the falling edge, so any
  // handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", bus.in_ready,
          enable && (bus.in_sel ? (qb.size() == 0 || bus.b_ready)
                                : (qa.size() == 0 || bus.a_ready)));
      chk("a_valid", bus.a_valid, qa.size() != 0);
      chk("b_valid", bus.b_valid, qb.size() != 0);
      if (bus.a_valid && qa.size() != 0) chk("a_data", bus.a_data, qa[0]);
      if (bus.b_valid && qb.size() != 0) chk("b_data", bus.b_data, qb[0]);
      chk("a_count", a_count, m_a_cnt);
      chk("b_count", b_count, m_b_cnt);
      if (bus.a_valid && bus.a_ready && qa.size() != 0) void'(qa.pop_front());
      if (bus.b_valid && bus.b_ready && qb.size() != 0) void'(qb.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_sel) begin
          qb.push_back(bus.in_data);
          m_b_cnt = m_b_cnt + 8'd1;
        end else begin
          qa.push_back(bus.in_data);
          m_a_cnt = m_a_cnt + 8'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic send(input logic [15:0] d, input logic s);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_valid = 1'b1;
    while (!done && n < 64) begin
      if (rnd) begin
        bus.a_ready = 1'($urandom_range(0, 1));
        bus.b_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      n++;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Assert reset between edges; optionally check the asynchronous clear.
  task automatic do_reset(input bit check);
    #2;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    m_a_cnt = 8'd0;
    m_b_cnt = 8'd0;
    #1;
    if (check) begin
      chk("rst_a_valid", bus.a_valid, 32'd0);
      chk("rst_b_valid", bus.b_valid, 32'd0);
      chk("rst_a_data", bus.a_data, 32'd0);
      chk("rst_b_data", bus.b_data, 32'd0);
      chk("rst_a_count", a_count, 32'd0);
      chk("rst_b_count", b_count, 32'd0);
      chk("rst_in_ready", bus.in_ready, enable);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    rst          = 1'b1;
    enable       = 1'b1;
    bus.in_data  = 16'h0000;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b1;
    bus.b_ready  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset mid-stream while channel A holds a word.
    bus.a_ready = 1'b0;
    send(16'h5A5A, 1'b0);
    chk("pre_rst_a_valid", bus.a_valid, 32'd1);
    do_reset(1'b1);

    // Single routing with both consumers ready.
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    send(16'h1234, 1'b0);
    chk("route_a_valid", bus.a_valid, 32'd1);
    chk("route_a_data", bus.a_data, 32'h1234);
    send(16'hBEEF, 1'b1);
    chk("route_b_valid", bus.b_valid, 32'd1);
    chk("route_b_data", bus.b_data, 32'hBEEF);
    chk("route_a_count", a_count, 32'd1);
    chk("route_b_count", b_count, 32'd1);
    tick();

    // Head-of-line isolation: A stalled, B still accepts.
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    send(16'h0001, 1'b0);
    bus.in_data  = 16'h0002;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hol_stall", bus.in_ready, 32'd0);
      tick();
    end
    send(16'h0003, 1'b1);
    chk("hol_b_data", bus.b_data, 32'h0003);
    chk("hol_a_data", bus.a_data, 32'h0001);
    chk("hol_a_valid", bus.a_valid, 32'd1);
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    repeat (2) tick();

    // Back-to-back drain+load on channel A: full rate, no bubbles.
    do_reset(1'b0);
    c0 = cyc;
    for (int i = 0; i < 10; i++) send(16'h00AA + 16'(i), 1'b0);
    chk("b2b_cycles", cyc - c0, 32'd10);
    chk("b2b_a_valid", bus.a_valid, 32'd1);
    chk("b2b_a_data", bus.a_data, 32'h00B3);
    chk("b2b_a_count", a_count, 32'd10);
    repeat (2) tick();

    // Enable gating: input blocked, held word still drains.
    bus.b_ready = 1'b0;
    send(16'h0BB0, 1'b1);
    enable       = 1'b0;
    bus.in_data  = 16'h7777;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b1;
    bus.b_ready  = 1'b1;
    @(negedge clk);
    chk("en_in_ready", bus.in_ready, 32'd0);
    tick();
    chk("en_b_valid", bus.b_valid, 32'd0);
    chk("en_a_count", a_count, 32'd10);
    chk("en_b_count", b_count, 32'd1);
    bus.in_valid = 1'b0;
    enable       = 1'b1;
    tick();

    // Counter wrap on channel B.
    do_reset(1'b0);
    for (int i = 0; i < 256; i++) send(16'(i * 3), 1'b1);
    chk("wrap_b_count", b_count, 32'd0);
    chk("wrap_a_count", a_count, 32'd0);
    repeat (2) tick();

    // Random routing with random consumer back-pressure.
    rnd = 1'b1;
    for (int i = 0; i < 150; i++) send(16'($urandom), 1'($urandom_range(0, 1)));
    rnd = 1'b0;
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    repeat (3) tick();
    chk("end_qa_empty", qa.size(), 32'd0);
    chk("end_qb_empty", qb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
# demux2_stream

Registered 1-to-2 stream demultiplexer, the distribution-side counterpart of the `mux2` selector: one N-bit input stream is steered by a per-word select bit into one of two output channels. Each output channel has a one-entry holding register with a valid/ready handshake, so a stalled consumer on one side does not block words destined for the other. It sits between a single producer (e.g. a writeback/result bus) and two consumers, such as a register-file write port and a memory/IO write port. Per-channel 8-bit transfer counters support debug and verification.

## Interface
- `N`, 16, data width in bits
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `enable`  input  1  1 = accept new input words; 0 = input blocked (stored words still drain)
- `in_data`  input  N  input word
- `in_sel`  input  1  destination: 0 = channel A, 1 = channel B
- `in_valid`  input  1  input word present
- `in_ready`  output  1  block can accept this cycle (combinational)
- `a_data`  output  N  channel A held word
- `a_valid`  output  1  channel A holds a word
- `a_ready`  input  1  channel A consumer accepts
- `b_data`  output  N  channel B held word
- `b_valid`  output  1  channel B holds a word
- `b_ready`  input  1  channel B consumer accepts
- `a_count`  output  8  words accepted into channel A since reset, modulo 256
- `b_count`  output  8  words accepted into channel B since reset, modulo 256

## Operation
- Slot A free_A = !a_valid || a_ready; free_B = !b_valid || b_ready.
- in_ready = enable && (in_sel ? free_B : free_A). Depends combinationally on enable, in_sel, x_valid, x_ready; no dependence on in_valid.
- Input transfer: in_valid && in_ready at a rising edge. Word loads into slot selected by in_sel; that slot's valid = 1 next cycle; that channel's count += 1 (wraps 255 -> 0).
- Output transfer on channel X: x_valid && x_ready at a rising edge. x_valid clears next cycle unless the same edge also loads slot X (then x_valid stays 1, x_data takes new word).
- Non-selected slot is unaffected by an input transfer; both channels may drain on the same edge.
- x_data holds its value when not loaded, including after drain (stale data, x_valid = 0). x_data only changes on an input transfer into slot X.
- enable = 0: in_ready = 0, no loads, counters frozen; held words still drain normally.
- in_valid with in_ready = 0: no state change; producer must hold in_data/in_sel stable until transfer.
- No state machine beyond the two slot valid bits; four slot states (empty/empty, A/empty, empty/B, A/B) with transitions as above.

## Timing
- Reset (async assert, applied immediately): a_valid = b_valid = 0, a_data = b_data = 0, a_count = b_count = 0; in_ready then = enable.
- Reset deassertion takes effect at the next rising edge; reset mid-operation discards held words and counts.
- Latency: word accepted at edge k appears with x_valid = 1 in cycle k+1 (one cycle).
- Throughput: one word per cycle to a channel whose consumer holds x_ready = 1 continuously (pass-through full rate, no bubbles).
- Full slot with x_ready = 0: input targeting that slot stalls; input targeting the other slot proceeds.

## Test plan
- Reset: assert rst mid-stream with a_valid = 1 -> a_valid, b_valid, a_data, b_data, counts read 0 immediately, before any clock edge.
- Single routing: enable = 1, send 16'h1234 sel 0 then 16'hBEEF sel 1, both readys 1 -> a_data = 16'h1234 valid one cycle after first edge, b_data = 16'hBEEF one cycle after second; a_count = 1, b_count = 1.
- Head-of-line isolation: a_ready = 0, send 16'h0001 sel 0, then 16'h0002 sel 0, then 16'h0003 sel 1 -> first accepted, second stalls (in_ready = 0) while in_sel = 0; switching producer to 16'h0003 sel 1 is accepted; b_data = 16'h0003; a_data stays 16'h0001.
- Simultaneous drain and load: a_valid = 1, a_ready = 1, send 16'h00AA sel 0 same edge -> a_valid stays 1, a_data = 16'h00AA, no bubble; 10 back-to-back words yield a_count = 10.
- Enable gating: enable = 0, in_valid = 1, b_valid = 1, b_ready = 1 -> in_ready = 0, b_valid clears next cycle, counts unchanged.
- Counter wrap: push 256 words to channel B -> b_count returns to 0, a_count unchanged.
